fa_bist_ctrl: RTL and testbench

//   Synthesizable built-in self-test controller for the 1-bit full-adder cell.
//   - Drives exhaustive a/b/cin stimulus into a full-adder instance.
//   - Samples s/cout and checks them against a golden sum.
//   - Reports busy/done/pass_ok and a saturating error count.
//   - Silicon-side counterpart of the simulation bench: the same 8-vector sweep, done in hardware.

---
 rtl/fa_bist_pkg.sv | 18 +
 rtl/fa_bist_golden.sv | 11 +
 rtl/fa_bist_ctrl.sv | 121 ++++++++++++
 tb/tb_fa_bist_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fa_bist_pkg.sv
// Shared types and golden model for the full-adder BIST controller.
package fa_bist_pkg;

  localparam int unsigned VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // vec = {a,b,cin}; result = {cout,s}
  function automatic logic [1:0] fa_golden(input logic [VEC_W-1:0] vec);
    fa_golden = 2'(vec[2]) + 2'(vec[1]) + 2'(vec[0]);
  endfunction

endpackage

// File: rtl/fa_bist_golden.sv
// Combinational golden reference: {a,b,cin} -> {cout,s}.
module fa_bist_golden
  import fa_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [1:0]       sum
);

  always_comb sum = fa_golden(vec);

endmodule

// File: rtl/fa_bist_ctrl.sv
// BIST controller sweeping all 8 full-adder input vectors and counting mismatches.
// Optional first-failure capture ports enabled by macro FA_BIST_ERRLOG_EN.
module fa_bist_ctrl
  import fa_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned N_PASSES      = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic             pass_ok,
  output logic [ERR_W-1:0] err_cnt
`ifdef FA_BIST_ERRLOG_EN
  ,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic [1:0]       first_fail_got
`endif
);

  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PASS_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(N_PASSES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  state_t              state;
  logic [VEC_W-1:0]    vec;
  logic [SET_W-1:0]    settle_cnt;
  logic [PASS_W-1:0]   pass;
  logic [ERR_W-1:0]    err_q;
  logic [1:0]          golden;
  logic                mismatch;
  logic                start_run;

  fa_bist_golden u_golden (
    .vec (vec),
    .sum (golden)
  );

  // Case-inequality so X/Z returned by the adder counts as a failure.
  always_comb begin
    mismatch  = ({fa_cout, fa_s} !== golden);
    start_run = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      pass       <= '0;
      err_q      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_run) begin
            state      <= SETTLE;
            vec        <= '0;
            settle_cnt <= '0;
            pass       <= '0;
            err_q      <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch && (err_q != ERR_MAX)) err_q <= err_q + 1'b1;
          if ((vec == '1) && (pass == PASS_LAST)) begin
            state <= DONE;
          end else begin
            vec   <= vec + 1'b1;
            if (vec == '1) pass <= pass + 1'b1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FA_BIST_ERRLOG_EN
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_got   <= '0;
    end else if ((state == CHECK) && mismatch && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_vec   <= vec;
      first_fail_got   <= {fa_cout, fa_s};
    end
  end
`endif

  always_comb begin
    fa_a    = vec[2];
    fa_b    = vec[1];
    fa_cin  = vec[0];
    busy    = (state == SETTLE) || (state == CHECK);
    done    = (state == DONE);
    pass_ok = (state == DONE) && (err_q == '0);
    err_cnt = err_q;
  end

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Directed bench for fa_bist_ctrl: three parameterisations, each driving a behavioural full adder with selectable faults.
module tb_fa_bist_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  logic [1:0] mode0, mode1, mode2;   // 0 good, 1 s stuck-at-0, 2 cout inverted

  int checks;
  int errors;

  logic fa_a0, fa_b0, fa_cin0, s0, co0, busy0, done0, pok0;
  logic fa_a1, fa_b1, fa_cin1, s1, co1, busy1, done1, pok1;
  logic fa_a2, fa_b2, fa_cin2, s2, co2, busy2, done2, pok2;
  logic [3:0] err0, err1, err2;
`ifdef FA_BIST_ERRLOG_EN
  logic       ffv0, ffv1, ffv2;
  logic [2:0] ffvec0, ffvec1, ffvec2;
  logic [1:0] ffgot0, ffgot1, ffgot2;
`endif

  // Behavioural adders with fault injection
  always_comb begin
    s0  = (mode0 == 2'd1) ? 1'b0 : (fa_a0 ^ fa_b0 ^ fa_cin0);
    co0 = ((fa_a0 & fa_b0) | (fa_a0 & fa_cin0) | (fa_b0 & fa_cin0)) ^ (mode0 == 2'd2);
    s1  = (mode1 == 2'd1) ? 1'b0 : (fa_a1 ^ fa_b1 ^ fa_cin1);
    co1 = ((fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1)) ^ (mode1 == 2'd2);
    s2  = (mode2 == 2'd1) ? 1'b0 : (fa_a2 ^ fa_b2 ^ fa_cin2);
    co2 = ((fa_a2 & fa_b2) | (fa_a2 & fa_cin2) | (fa_b2 & fa_cin2)) ^ (mode2 == 2'd2);
  end

  fa_bist_ctrl #(.SETTLE_CYCLES(1), .N_PASSES(1), .ERR_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .fa_a(fa_a0), .fa_b(fa_b0), .fa_cin(fa_cin0), .fa_s(s0), .fa_cout(co0),
    .busy(busy0), .done(done0), .pass_ok(pok0), .err_cnt(err0)
`ifdef FA_BIST_ERRLOG_EN
    , .first_fail_valid(ffv0), .first_fail_vec(ffvec0), .first_fail_got(ffgot0)
`endif
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(1), .N_PASSES(2), .ERR_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(s1), .fa_cout(co1),
    .busy(busy1), .done(done1), .pass_ok(pok1), .err_cnt(err1)
`ifdef FA_BIST_ERRLOG_EN
    , .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_got(ffgot1)
`endif
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(3), .N_PASSES(1), .ERR_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]),
    .fa_a(fa_a2), .fa_b(fa_b2), .fa_cin(fa_cin2), .fa_s(s2), .fa_cout(co2),
    .busy(busy2), .done(done2), .pass_ok(pok2), .err_cnt(err2)
`ifdef FA_BIST_ERRLOG_EN
    , .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .first_fail_got(ffgot2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int idx);
    case (idx)
      0: done_of = done0;
      1: done_of = done1;
      default: done_of = done2;
    endcase
  endfunction

  function automatic logic busy_of(input int idx);
    case (idx)
      0: busy_of = busy0;
      1: busy_of = busy1;
      default: busy_of = busy2;
    endcase
  endfunction

  // Pulse start for one edge, then count cycles (after that edge) until done.
  task automatic run_dut(input int idx, input int budget, output int lat, output int nbusy);
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_v[idx] = 1'b0;
    lat   = -1;
    nbusy = 0;
    for (int k = 0; k < budget; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done_of(idx)) begin
        lat = k;
        break;
      end
      if (busy_of(idx)) nbusy++;
    end
  endtask

  int lat, nbusy, lat2;
  logic found;

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start_v = '0;
    mode0   = 2'd0;
    mode1   = 2'd2;
    mode2   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",  busy0, 0);
    check_eq("rst_done",  done0, 0);
    check_eq("rst_pok",   pok0, 0);
    check_eq("rst_err",   err0, 0);
    check_eq("rst_vec",   {fa_a0, fa_b0, fa_cin0}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Good adder, default parameters
    run_dut(0, 40, lat, nbusy);
    check_eq("good_lat",   lat, 16);
    check_eq("good_busy",  nbusy, 16);
    check_eq("good_err",   err0, 0);
    check_eq("good_pok",   pok0, 1);
    check_eq("good_bsyd",  busy0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("good_hold",  done0, 1);

    // s stuck-at-0, started from DONE
    mode0 = 2'd1;
    run_dut(0, 40, lat, nbusy);
    check_eq("s0_lat",  lat, 16);
    check_eq("s0_err",  err0, 4);
    check_eq("s0_pok",  pok0, 0);
`ifdef FA_BIST_ERRLOG_EN
    check_eq("s0_ffv",   ffv0, 1);
    check_eq("s0_ffvec", ffvec0, 3'b001);
    check_eq("s0_ffgot", ffgot0, 2'b00);
`endif

    // Second good run from DONE repeats the first result
    mode0 = 2'd0;
    run_dut(0, 40, lat, nbusy);
    check_eq("rerun_lat", lat, 16);
    check_eq("rerun_err", err0, 0);
    check_eq("rerun_pok", pok0, 1);
`ifdef FA_BIST_ERRLOG_EN
    check_eq("rerun_ffv", ffv0, 0);
`endif

    // cout inverted, two passes: 16 mismatches saturate at 15
    run_dut(1, 60, lat, nbusy);
    check_eq("inv_lat",  lat, 32);
    check_eq("inv_busy", nbusy, 32);
    check_eq("inv_err",  err1, 15);
    check_eq("inv_pok",  pok1, 0);

    // SETTLE_CYCLES=3: each vector held 4 cycles, extra starts ignored
    @(negedge clk);
    start_v[2] = 1'b1;
    @(posedge clk);
    #1;
    start_v[2] = 1'b0;
    lat2 = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k < 32) check_eq($sformatf("hold_%0d", k), {fa_a2, fa_b2, fa_cin2}, k / 4);
      if (done2 && lat2 < 0) lat2 = k;
      start_v[2] = (k == 5) || (k == 20);
    end
    start_v[2] = 1'b0;
    check_eq("s3_lat", lat2, 32);
    check_eq("s3_err", err2, 0);
    check_eq("s3_pok", pok2, 1);

    // rst mid-run at vec 011
    mode0 = 2'd1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ({fa_a0, fa_b0, fa_cin0} == 3'b011) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq("mid_found", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_busy", busy0, 0);
    check_eq("mid_done", done0, 0);
    check_eq("mid_err",  err0, 0);
    check_eq("mid_vec",  {fa_a0, fa_b0, fa_cin0}, 0);
    check_eq("mid_pok",  pok0, 0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("mid_nodone", done0, 0);

    // start together with rst: rst wins
    @(negedge clk);
    rst        = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_start_busy", busy0, 0);
    start_v[0] = 1'b0;
    rst        = 1'b0;

    // Clean run after reset
    mode0 = 2'd0;
    run_dut(0, 40, lat, nbusy);
    check_eq("post_lat", lat, 16);
    check_eq("post_err", err0, 0);
    check_eq("post_pok", pok0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
